// File: rtl/jtroadf_romarb.sv
// jtroadf_romarb: shares one SDRAM ROM slot between the object line drawer
// (obj) and the scroll-tile fetcher (scr) of the Road Fighter video.
// Each requester keeps its last fetched word together with an address tag,
// so repeating an address is answered combinationally with no SDRAM access.
//
// Handshake: a requester holds X_cs and X_addr steady until X_ok is high;
// X_ok is high exactly when X_data belongs to the current X_addr. Towards
// the SDRAM, rom_cs/rom_addr are held until rom_ok is sampled in the WAIT
// state; rom_ok at any other time is ignored.
module jtroadf_romarb #(
    parameter int AW        = 14,
    parameter bit OBJ_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          obj_cs,
    input  logic [AW-1:0] obj_addr,
    output logic [31:0]   obj_data,
    output logic          obj_ok,
    input  logic          scr_cs,
    input  logic [AW-1:0] scr_addr,
    output logic [31:0]   scr_data,
    output logic          scr_ok,
    output logic          rom_cs,
    output logic [AW:0]   rom_addr,
    input  logic [31:0]   rom_data,
    input  logic          rom_ok,
    output logic [1:0]    st_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state, state_nx;

    logic [AW-1:0] tag_obj, tag_scr;
    logic          vld_obj, vld_scr;
    logic          hit_obj, hit_scr;
    logic          need_obj, need_scr;

    // round-robin history: hist_vld clears on reset, last_obj names the
    // owner of the last completed access
    logic          hist_vld, last_obj;

    logic          start, pick_obj, done, keep;
    logic          own_obj;
    logic          own_cs;
    logic [AW-1:0] own_addr;

    assign st_dbg   = state;

    assign hit_obj  = vld_obj & (obj_addr == tag_obj);
    assign hit_scr  = vld_scr & (scr_addr == tag_scr);
    assign obj_ok   = obj_cs & hit_obj;
    assign scr_ok   = scr_cs & hit_scr;
    assign need_obj = obj_cs & ~hit_obj;
    assign need_scr = scr_cs & ~hit_scr;

    // the owner of the access in flight is the MSB of the latched address
    assign own_obj  = rom_addr[AW];
    assign own_cs   = own_obj ? obj_cs   : scr_cs;
    assign own_addr = own_obj ? obj_addr : scr_addr;
    // data is kept only if the owner still wants the word it asked for
    assign keep     = done & own_cs & (own_addr == rom_addr[AW-1:0]);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // next state, arbitration and completion decode
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        pick_obj = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (need_obj | need_scr) begin
                    start    = 1'b1;
                    state_nx = ST_ISSUE;
                    if (need_obj & need_scr)
                        pick_obj = hist_vld ? ~last_obj : OBJ_FIRST;
                    else
                        pick_obj = need_obj;
                end
            end
            // a stale rom_ok from the previous access must not complete this one
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (rom_ok) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // SDRAM request, round-robin history and per-requester word stores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            hist_vld <= 1'b0;
            last_obj <= 1'b0;
            tag_obj  <= '0;
            tag_scr  <= '0;
            vld_obj  <= 1'b0;
            vld_scr  <= 1'b0;
            obj_data <= '0;
            scr_data <= '0;
        end else begin
            if (start) begin
                rom_cs   <= 1'b1;
                rom_addr <= {pick_obj, pick_obj ? obj_addr : scr_addr};
            end else if (done) begin
                rom_cs   <= 1'b0;
            end
            if (done) begin
                hist_vld <= 1'b1;
                last_obj <= own_obj;
            end
            if (keep && own_obj) begin
                obj_data <= rom_data;
                tag_obj  <= rom_addr[AW-1:0];
                vld_obj  <= 1'b1;
            end
            if (keep && !own_obj) begin
                scr_data <= rom_data;
                tag_scr  <= rom_addr[AW-1:0];
                vld_scr  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/jtroadf_romarb.md
# jtroadf_romarb

Two-requester arbiter sharing one SDRAM ROM slot between the object line drawer and the scroll-tile fetcher of the Road Fighter video. It latches the winning request, holds it on the SDRAM bus until acknowledged, and stores each requester's last fetched word with a valid address tag. A requester repeating its address is served from that store without a new SDRAM access. It sits between the two fetch engines and the framework SDRAM slot.

## Interface
Parameters:
- AW, 14: requester address width; the SDRAM address is AW+1 bits.
- OBJ_FIRST, 1: with round-robin history cleared, simultaneous requests go to obj (1) or scr (0).

Ports:
- clk  in  1  48 MHz video clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- obj_cs  in  1  object drawer request.
- obj_addr  in  AW  object ROM word address.
- obj_data  out  32  last word fetched for obj.
- obj_ok  out  1  obj_data valid for the current obj_addr.
- scr_cs  in  1  scroll fetcher request.
- scr_addr  in  AW  scroll ROM word address.
- scr_data  out  32  last word fetched for scr.
- scr_ok  out  1  scr_data valid for the current scr_addr.
- rom_cs  out  1  SDRAM slot request.
- rom_addr  out  AW+1  {owner, address}; MSB 1 selects the object region, 0 the scroll region.
- rom_data  in  32  SDRAM read data.
- rom_ok  in  1  SDRAM data valid.

## Operation
- Per requester X, keep a tag tag_X (AW bits), a flag vld_X and data_X.
- hit_X = vld_X & (X_addr == tag_X).
- X_ok = X_cs & hit_X. This output is combinational.
- need_X = X_cs & ~hit_X.
- State machine IDLE / ISSUE / WAIT:
  - IDLE: if any need_X, choose the owner, latch {owner, X_addr} into rom_addr, set rom_cs=1 and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: lasts one cycle. rom_ok is ignored in this state so that a stale ok from the previous access is not taken. Go to WAIT.
  - WAIT: hold rom_cs=1 and rom_addr. When rom_ok=1:
    - clear rom_cs and go to IDLE;
    - if the owner's current address still equals the latched address and its cs is high, write data_owner=rom_data, tag_owner=latched address, vld_owner=1;
    - otherwise discard the data. The tag and vld are unchanged.
- Owner choice:
  - One requester needs service: that requester wins.
  - Both need service: the requester that did not own the last completed access wins.
  - No history after reset: the OBJ_FIRST parameter decides.
- A requester changing its address mid-access does not abort the access. The SDRAM transaction always completes; the result is dropped and re-arbitration happens in IDLE.
- Dropping cs never clears vld. A later request to the same address hits immediately.
- The fetch path of one requester never writes the data, tag or vld of the other requester.

## Timing
- Reset values: rom_cs=0, rom_addr=0, data_X=0, vld_X=0, state IDLE, round-robin history cleared. X_ok=0 follows from vld_X=0.
- Miss latency:
  - need_X is seen at cycle n;
  - rom_cs rises at n+1 (ISSUE);
  - rom_ok is first eligible at n+2;
  - if rom_ok is accepted at cycle m, X_data and X_ok are valid at m+1.
- rom_cs is low for at least one cycle between back-to-back accesses (the IDLE cycle).
- Hit latency: zero cycles. X_ok follows X_addr and X_cs combinationally.
- rom_ok in IDLE is ignored. rom_ok high in WAIT for several cycles completes exactly one access.
- A reset mid-access returns the block to the reset values immediately. The SDRAM controller handles the dropped rom_cs.
- Worst-case wait for a requester, with both requesting continuously: one full access of the other requester plus its own.

## Test plan
- Reset, then obj_cs=1, obj_addr=0x0123, rom_ok 4 cycles after rom_cs. Required:
  - rom_addr=0x4123 one cycle after the request;
  - obj_data equals rom_data and obj_ok=1 one cycle after rom_ok;
  - rom_cs then low.
- After that fetch, drop obj_cs for 10 cycles, then raise it again at 0x0123. Required: obj_ok=1 in the same cycle and no rom_cs pulse.
- scr_cs and obj_cs rise in the same cycle after reset, with OBJ_FIRST=1. Required:
  - first rom_addr=0x4xxx (obj), second 0x0xxx (scr);
  - one rom_cs-low cycle between the two accesses;
  - a third simultaneous miss goes to obj.
- Change obj_addr from 0x0010 to 0x0011 while in WAIT. Required:
  - the first access completes and its data is discarded (obj_ok stays 0);
  - a new access with rom_addr=0x4011 follows.
- Hold rom_ok high across the IDLE→ISSUE boundary. Required: no completion in ISSUE; the access completes only on rom_ok sampled in WAIT.
- Assert rst during WAIT. Required: rom_cs=0, obj_ok=scr_ok=0 and state IDLE in the same cycle. After release, a new request starts cleanly.
